// File: rtl/axis_phase_unwrapper.sv
// axis_phase_unwrapper: turns a wrapped two's-complement phase stream into a
// continuous signed phase by accumulating the modular difference of
// successive samples. A 4-state FSM seeds, runs and drains on `enable`.
// Optional build macro PHASE_UNWRAP_SATURATE_EN makes the accumulator
// saturate instead of wrapping modulo 2^AXIS_TDATA_WIDTH.
module axis_phase_unwrapper #(
    parameter int PHASE_WIDTH      = 16,
    parameter int AXIS_TDATA_WIDTH = 32
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        enable,
    input  logic [PHASE_WIDTH-1:0]      S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic                        S_AXIS_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    output logic [15:0]                 wrap_count
);

    localparam int PW = PHASE_WIDTH;
    localparam int AW = AXIS_TDATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   p_prev_q, p_prev_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [AW-1:0]   tdata_q, tdata_d;
    logic            tvalid_q, tvalid_d;
    logic [15:0]     wcnt_q, wcnt_d;

    logic            accepting;
    logic            s_ready;
    logic            in_xfer;
    logic            out_xfer;
    logic [PW:0]     raw_diff;
    logic [PW-1:0]   diff;
    logic            wrap_evt;
    logic [AW-1:0]   diff_ext;
    logic [AW-1:0]   p_ext;
    logic [AW-1:0]   acc_next;
`ifdef PHASE_UNWRAP_SATURATE_EN
    logic [AW:0]     sum_wide;
`endif

    // Handshake qualifiers and the modular phase step
    always_comb begin
        accepting = (state_q == S_FIRST) || (state_q == S_RUN);
        s_ready   = accepting && (!tvalid_q || M_AXIS_tready);
        in_xfer   = S_AXIS_tvalid && s_ready;
        out_xfer  = tvalid_q && M_AXIS_tready;

        // Difference computed one bit wider; the low PW bits are the
        // wrapped step, and a mismatch of the top two bits marks a wrap.
        raw_diff = {S_AXIS_tdata[PW-1], S_AXIS_tdata} - {p_prev_q[PW-1], p_prev_q};
        diff     = raw_diff[PW-1:0];
        wrap_evt = raw_diff[PW] != raw_diff[PW-1];
        diff_ext = {{(AW-PW){diff[PW-1]}}, diff};
        p_ext    = {{(AW-PW){S_AXIS_tdata[PW-1]}}, S_AXIS_tdata};
    end

    // Accumulator update, wrapping or saturating depending on the build
    always_comb begin
`ifdef PHASE_UNWRAP_SATURATE_EN
        sum_wide = {acc_q[AW-1], acc_q} + {diff_ext[AW-1], diff_ext};
        if (sum_wide[AW] != sum_wide[AW-1]) begin
            acc_next = sum_wide[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
        end else begin
            acc_next = sum_wide[AW-1:0];
        end
`else
        acc_next = acc_q + diff_ext;
`endif
    end

    // FSM next state, accumulator, wrap counter and output register loads
    always_comb begin
        state_d  = state_q;
        p_prev_d = p_prev_q;
        acc_d    = acc_q;
        wcnt_d   = wcnt_q;

        // Output stays valid until drained without a replacing input
        if (in_xfer) begin
            tvalid_d = 1'b1;
        end else if (out_xfer) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_FIRST;
                end
            end
            S_FIRST: begin
                if (in_xfer) begin
                    p_prev_d = S_AXIS_tdata;
                    acc_d    = p_ext;
                    state_d  = S_RUN;
                end
                if (!enable) begin
                    state_d = tvalid_d ? S_DRAIN : S_IDLE;
                end
            end
            S_RUN: begin
                if (in_xfer) begin
                    p_prev_d = S_AXIS_tdata;
                    acc_d    = acc_next;
                    if (wrap_evt) begin
                        wcnt_d = wcnt_q + 16'd1;
                    end
                end
                if (!enable) begin
                    state_d = tvalid_d ? S_DRAIN : S_IDLE;
                end
            end
            S_DRAIN: begin
                if (!tvalid_d) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        tdata_d = in_xfer ? acc_d : tdata_q;
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q  <= S_IDLE;
            p_prev_q <= '0;
            acc_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            wcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            p_prev_q <= p_prev_d;
            acc_q    <= acc_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            wcnt_q   <= wcnt_d;
        end
    end

    assign S_AXIS_tready = s_ready;
    assign M_AXIS_tdata  = tdata_q;
    assign M_AXIS_tvalid = tvalid_q;
    assign wrap_count    = wcnt_q;

endmodule

// File: tb/tb_axis_phase_unwrapper.sv
// Directed bench for axis_phase_unwrapper: a vector table for the unwrap
// arithmetic plus hand sequences for backpressure, enable drain, overflow
// (on a 20-bit output instance) and mid-stream reset.
module tb_axis_phase_unwrapper;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic [15:0] S_AXIS_tdata;
    logic        S_AXIS_tvalid;
    logic        S_AXIS_tready;
    logic [31:0] M_AXIS_tdata;
    logic        M_AXIS_tvalid;
    logic        M_AXIS_tready;
    logic [15:0] wrap_count;

    logic        s20_tready;
    logic [19:0] m20_tdata;
    logic        m20_tvalid;
    logic [15:0] wc20;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 aclk = ~aclk;

    axis_phase_unwrapper #(.PHASE_WIDTH(16), .AXIS_TDATA_WIDTH(32)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid),
        .S_AXIS_tready(S_AXIS_tready),
        .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tvalid(M_AXIS_tvalid),
        .M_AXIS_tready(M_AXIS_tready), .wrap_count(wrap_count)
    );

    axis_phase_unwrapper #(.PHASE_WIDTH(16), .AXIS_TDATA_WIDTH(20)) dut20 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tvalid(S_AXIS_tvalid),
        .S_AXIS_tready(s20_tready),
        .M_AXIS_tdata(m20_tdata), .M_AXIS_tvalid(m20_tvalid),
        .M_AXIS_tready(M_AXIS_tready), .wrap_count(wc20)
    );

    typedef struct {
        logic        reseed;
        int          p;
        longint      exp;
        int          exp_wc;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Drop enable long enough to reach IDLE, then return to FIRST
    task automatic reseed();
        S_AXIS_tvalid = 1'b0;
        enable = 1'b0;
        repeat (2) tick();
        enable = 1'b1;
        tick();
    endtask

    initial begin
        longint exp20;
        logic [19:0] t20;

        vecs[0]  = '{1'b1,  32000,  32000, 0};
        vecs[1]  = '{1'b0,  32700,  32700, 0};
        vecs[2]  = '{1'b0, -32700,  32836, 1};
        vecs[3]  = '{1'b1, -32000, -32000, 1};
        vecs[4]  = '{1'b0, -32700, -32700, 1};
        vecs[5]  = '{1'b0,  32700, -32836, 2};
        vecs[6]  = '{1'b1,      0,      0, 2};
        vecs[7]  = '{1'b0,    100,    100, 2};
        vecs[8]  = '{1'b0,   -100,   -100, 2};
        vecs[9]  = '{1'b0,  32767, -32769, 3};
        vecs[10] = '{1'b0, -32768, -32768, 4};
        vecs[11] = '{1'b0,      0, -65536, 5};
        vecs[12] = '{1'b0, -32768, -98304, 5};

        aresetn = 1'b0;
        enable = 1'b0;
        S_AXIS_tdata = '0;
        S_AXIS_tvalid = 1'b0;
        M_AXIS_tready = 1'b1;
        repeat (3) tick();
        chk("reset_tdata", longint'(M_AXIS_tdata), 0);
        chk("reset_tvalid", longint'(M_AXIS_tvalid), 0);
        chk("reset_s_tready", longint'(S_AXIS_tready), 0);
        chk("reset_wrap_count", longint'(wrap_count), 0);
        aresetn = 1'b1;
        tick();

        // Unwrap arithmetic table
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].reseed) reseed();
            S_AXIS_tdata = 16'(vecs[i].p);
            S_AXIS_tvalid = 1'b1;
            chk("vec_s_tready", longint'(S_AXIS_tready), 1);
            tick();
            chk("vec_tvalid", longint'(M_AXIS_tvalid), 1);
            chk("vec_tdata", longint'($signed(M_AXIS_tdata)), vecs[i].exp);
            chk("vec_wrap_count", longint'(wrap_count), longint'(vecs[i].exp_wc));
        end

        // Backpressure
        reseed();
        S_AXIS_tdata = 16'd100;
        S_AXIS_tvalid = 1'b1;
        tick();
        chk("bp_first", longint'($signed(M_AXIS_tdata)), 100);
        M_AXIS_tready = 1'b0;
        S_AXIS_tdata = 16'd200;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("bp_hold_tdata", longint'($signed(M_AXIS_tdata)), 100);
            chk("bp_hold_tvalid", longint'(M_AXIS_tvalid), 1);
            chk("bp_s_tready", longint'(S_AXIS_tready), 0);
        end
        M_AXIS_tready = 1'b1;
        tick();
        chk("bp_rel_200", longint'($signed(M_AXIS_tdata)), 200);
        S_AXIS_tdata = 16'd300;
        tick();
        chk("bp_rel_300", longint'($signed(M_AXIS_tdata)), 300);
        chk("bp_rel_tvalid", longint'(M_AXIS_tvalid), 1);

        // Enable drop with pending output, then reseed with 5
        M_AXIS_tready = 1'b0;
        S_AXIS_tdata = 16'd999;
        enable = 1'b0;
        tick();
        chk("drain_s_tready", longint'(S_AXIS_tready), 0);
        chk("drain_hold", longint'($signed(M_AXIS_tdata)), 300);
        tick();
        chk("drain_hold_tvalid", longint'(M_AXIS_tvalid), 1);
        chk("drain_hold2", longint'($signed(M_AXIS_tdata)), 300);
        M_AXIS_tready = 1'b1;
        chk("drain_s_tready2", longint'(S_AXIS_tready), 0);
        tick();
        chk("drain_done_tvalid", longint'(M_AXIS_tvalid), 0);
        S_AXIS_tdata = 16'd5;
        enable = 1'b1;
        tick();
        chk("reen_tvalid", longint'(M_AXIS_tvalid), 0);
        tick();
        chk("reen_seed", longint'($signed(M_AXIS_tdata)), 5);
        chk("reen_tvalid2", longint'(M_AXIS_tvalid), 1);

        // Overflow on the 20-bit instance
        S_AXIS_tvalid = 1'b0;
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        enable = 1'b1;
        tick();
        for (int k = 0; k < 40; k++) begin
            S_AXIS_tdata = 16'(k * 16384);
            S_AXIS_tvalid = 1'b1;
            tick();
            exp20 = longint'(k) * 16384;
`ifdef PHASE_UNWRAP_SATURATE_EN
            if (exp20 > 524287) exp20 = 524287;
`else
            t20 = exp20[19:0];
            exp20 = longint'($signed(t20));
`endif
            chk("ovf_tdata20", longint'($signed(m20_tdata)), exp20);
        end
        t20 = m20_tdata;

        // Reset during continuous streaming
        S_AXIS_tdata = 16'd77;
        aresetn = 1'b0;
        tick();
        chk("mrst_tvalid", longint'(M_AXIS_tvalid), 0);
        chk("mrst_wrap_count", longint'(wrap_count), 0);
        chk("mrst_s_tready", longint'(S_AXIS_tready), 0);
        chk("mrst_tdata", longint'(M_AXIS_tdata), 0);
        aresetn = 1'b1;
        S_AXIS_tvalid = 1'b0;
        tick();
        chk("mrst_first_ready", longint'(S_AXIS_tready), 1);
        S_AXIS_tdata = 16'd1234;
        S_AXIS_tvalid = 1'b1;
        tick();
        chk("mrst_seed", longint'($signed(M_AXIS_tdata)), 1234);
        chk("mrst_seed_wc", longint'(wrap_count), 0);
        S_AXIS_tvalid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_phase_unwrapper.md
# axis_phase_unwrapper

AXI-Stream stage directly upstream of `axis_differentiator`. Takes the wrapped phase from the demodulator's arctangent stage and produces a continuous, unwrapped 32-bit phase (displacement) stream for the differentiator to turn into velocity. Wrap correction uses modular subtraction of successive samples; a 4-state FSM handles seeding, running and clean shutdown on `enable`.

## Interface
- `PHASE_WIDTH`, 16: width of the signed wrapped input phase; full scale ±2^(PHASE_WIDTH-1) codes = ±π.
- `AXIS_TDATA_WIDTH`, 32: width of the signed unwrapped output; must be ≥ PHASE_WIDTH+1.

- `aclk`  in  1  clock; all logic on its rising edge.
- `aresetn`  in  1  reset; synchronous, active-low.
- `enable`  in  1  run control; low forces the stage toward IDLE.
- `S_AXIS_tdata`  in  PHASE_WIDTH  wrapped phase, two's complement.
- `S_AXIS_tvalid`  in  1  input valid.
- `S_AXIS_tready`  out  1  input ready.
- `M_AXIS_tdata`  out  AXIS_TDATA_WIDTH  unwrapped phase, two's complement.
- `M_AXIS_tvalid`  out  1  output valid.
- `M_AXIS_tready`  in  1  output ready.
- `wrap_count`  out  16  number of wrap corrections applied, modulo 2^16.

## Operation
- Reset values: `M_AXIS_tdata`=0, `M_AXIS_tvalid`=0, `S_AXIS_tready`=0, `wrap_count`=0, state=IDLE, internal `p_prev`=0, `acc`=0.
- Input transfer: `S_AXIS_tvalid && S_AXIS_tready` on a clock edge. Output transfer: `M_AXIS_tvalid && M_AXIS_tready`.
- `S_AXIS_tready` = (state is FIRST or RUN) && (!`M_AXIS_tvalid` || `M_AXIS_tready`), combinational from registered state.
- FSM:
  - IDLE: no input accepted. If `enable`=1, go to FIRST.
  - FIRST: on the first input transfer, `p_prev`←p, `acc`←sign_extend(p), output loaded, go to RUN. If `enable`=0, go to IDLE.
  - RUN: on each input transfer, d = (p − `p_prev`) mod 2^PHASE_WIDTH as signed, so d ∈ [−2^(PHASE_WIDTH-1), 2^(PHASE_WIDTH-1)). Then `acc`←`acc`+sign_extend(d), `p_prev`←p, and output loaded with the new `acc`. If `enable`=0, go to DRAIN, or to IDLE when no output is pending.
  - DRAIN: no input accepted. Hold the pending output until it transfers, then go to IDLE.
- Wrap event: the (PHASE_WIDTH+1)-bit raw difference p − `p_prev` ≠ sign_extend(d). Each wrap event in RUN increments `wrap_count` in the same cycle as the `acc` update. `wrap_count` is cleared only by reset.
- Re-entering FIRST reseeds `acc` from the next sample. The previous accumulation is discarded.
- Output register: loaded on an input transfer. `M_AXIS_tvalid` stays set until an output transfer with no simultaneous input transfer. `M_AXIS_tdata` and `M_AXIS_tvalid` are stable while `M_AXIS_tvalid`=1 and `M_AXIS_tready`=0.
- Accumulator overflow: `acc` wraps modulo 2^AXIS_TDATA_WIDTH, unless the saturation feature is compiled in.

## Timing
- Latency: input transfer at edge N → `M_AXIS_tvalid`=1 with the corresponding data after edge N.
- Throughput: one sample per cycle while `M_AXIS_tready`=1. A simultaneous output transfer and input transfer replace the output with no bubble.
- `enable` is sampled per edge. When it falls, no input transfer occurs in the following cycle.
- Reset mid-operation: on the edge where `aresetn`=0, all outputs return to their reset values. Pending data is lost. No partial transfer is allowed.

## Configuration
- `PHASE_UNWRAP_SATURATE_EN` defined: the `acc` update saturates to 2^(AXIS_TDATA_WIDTH-1)−1 or −2^(AXIS_TDATA_WIDTH-1) and never wraps. A saturated update still counts wrap events.
- Not defined: `acc` wraps modulo 2^AXIS_TDATA_WIDTH.

## Test plan
- Wrap-across-π: PHASE_WIDTH=16, `enable`=1, inputs 32000, 32700, −32700 → outputs 32000, 32700, 32836; `wrap_count`=1.
- Negative wrap: inputs −32000, −32700, 32700 → outputs −32000, −32700, −32836; `wrap_count` increments by 1.
- Backpressure: stream 100, 200, 300 with `M_AXIS_tready`=0 for 3 cycles after the first output → `M_AXIS_tdata` holds 100, `S_AXIS_tready`=0, `M_AXIS_tvalid` stays 1. On release, 200 and 300 follow in consecutive cycles.
- Enable drop with pending output: `enable`→0 while `M_AXIS_tready`=0 with output 300 pending → no further input accepted and 300 delivered once `M_AXIS_tready`=1. Re-enabling with input 5 → output 5 (reseeded).
- Overflow: AXIS_TDATA_WIDTH=20, ramp from 0 with step +16384 for 40 samples → with the macro, outputs clamp at 524287 from sample 32 on. Without it, sample 32 outputs −524288.
- Reset mid-stream: assert `aresetn`=0 for 1 cycle during continuous streaming → `M_AXIS_tvalid`=0, `wrap_count`=0, state IDLE. The next sample after reset is seeded as FIRST.
